// File: rtl/qconv_loop_sequencer.sv
// Loop-control FSM for the quantised convolution engine: walks oc/ic/kh/kw with
// run-time bounds, issues handshaked compute steps, drains the pipeline and stores per oc block.
module qconv_loop_sequencer #(
  parameter int OcHighBitWidth = 4,
  parameter int IcHighBitWidth = 4,
  parameter int KBitWidth      = 2,
  parameter int PipeDepth      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [OcHighBitWidth-1:0] oc_high_num,
  input  logic [IcHighBitWidth-1:0] ic_high_num,
  input  logic [KBitWidth-1:0]      kh_num,
  input  logic [KBitWidth-1:0]      kw_num,
  output logic                      step_valid,
  input  logic                      step_ready,
  output logic [OcHighBitWidth-1:0] oc_idx,
  output logic [IcHighBitWidth-1:0] ic_idx,
  output logic [KBitWidth-1:0]      kh_idx,
  output logic [KBitWidth-1:0]      kw_idx,
  output logic                      acc_clear,
  output logic                      acc_last,
  output logic                      store_valid,
  input  logic                      store_ready,
  output logic                      busy,
  output logic                      finish
);

  localparam int DrainW = $clog2(PipeDepth + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPUTE = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_STORE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [OcHighBitWidth-1:0] oc_q, oc_d, oc_num_q, oc_num_d;
  logic [IcHighBitWidth-1:0] ic_q, ic_d, ic_num_q, ic_num_d;
  logic [KBitWidth-1:0]      kh_q, kh_d, kh_num_q, kh_num_d;
  logic [KBitWidth-1:0]      kw_q, kw_d, kw_num_q, kw_num_d;
  logic [DrainW-1:0]         drain_q, drain_d;

  logic oc_last, ic_last, kh_last, kw_last, any_zero;

  // Counts are guaranteed non-zero whenever these comparisons are consulted.
  assign oc_last  = (oc_q == oc_num_q - OcHighBitWidth'(1));
  assign ic_last  = (ic_q == ic_num_q - IcHighBitWidth'(1));
  assign kh_last  = (kh_q == kh_num_q - KBitWidth'(1));
  assign kw_last  = (kw_q == kw_num_q - KBitWidth'(1));
  assign any_zero = (oc_high_num == '0) || (ic_high_num == '0) ||
                    (kh_num == '0) || (kw_num == '0);

  always_comb begin
    state_d  = state_q;
    oc_d     = oc_q;
    ic_d     = ic_q;
    kh_d     = kh_q;
    kw_d     = kw_q;
    oc_num_d = oc_num_q;
    ic_num_d = ic_num_q;
    kh_num_d = kh_num_q;
    kw_num_d = kw_num_q;
    drain_d  = drain_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          oc_num_d = oc_high_num;
          ic_num_d = ic_high_num;
          kh_num_d = kh_num;
          kw_num_d = kw_num;
          oc_d     = '0;
          ic_d     = '0;
          kh_d     = '0;
          kw_d     = '0;
          state_d  = any_zero ? S_DONE : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (step_ready) begin
          if (ic_last && kh_last && kw_last) begin
            state_d = S_DRAIN;
            drain_d = DrainW'(PipeDepth);
          end else if (!kw_last) begin
            kw_d = kw_q + KBitWidth'(1);
          end else begin
            kw_d = '0;
            if (!kh_last) begin
              kh_d = kh_q + KBitWidth'(1);
            end else begin
              kh_d = '0;
              ic_d = ic_q + IcHighBitWidth'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DrainW'(1);
        if (drain_q == DrainW'(1)) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (store_ready) begin
          if (oc_last) begin
            state_d = S_DONE;
          end else begin
            oc_d    = oc_q + OcHighBitWidth'(1);
            ic_d    = '0;
            kh_d    = '0;
            kw_d    = '0;
            state_d = S_COMPUTE;
          end
        end
      end
      S_DONE: begin
        oc_d    = '0;
        ic_d    = '0;
        kh_d    = '0;
        kw_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any handshake taken in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      oc_d    = '0;
      ic_d    = '0;
      kh_d    = '0;
      kw_d    = '0;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      oc_q     <= '0;
      ic_q     <= '0;
      kh_q     <= '0;
      kw_q     <= '0;
      oc_num_q <= '0;
      ic_num_q <= '0;
      kh_num_q <= '0;
      kw_num_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      oc_q     <= oc_d;
      ic_q     <= ic_d;
      kh_q     <= kh_d;
      kw_q     <= kw_d;
      oc_num_q <= oc_num_d;
      ic_num_q <= ic_num_d;
      kh_num_q <= kh_num_d;
      kw_num_q <= kw_num_d;
      drain_q  <= drain_d;
    end
  end

  assign step_valid  = (state_q == S_COMPUTE);
  assign store_valid = (state_q == S_STORE);
  assign finish      = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign oc_idx      = oc_q;
  assign ic_idx      = ic_q;
  assign kh_idx      = kh_q;
  assign kw_idx      = kw_q;
  assign acc_clear   = step_valid && (ic_q == '0) && (kh_q == '0) && (kw_q == '0);
  assign acc_last    = step_valid && ic_last && kh_last && kw_last;

endmodule

// File: tb/tb_qconv_loop_sequencer.sv
// Bench for qconv_loop_sequencer: nested-loop reference model of the step/store
// sequence, directed timing scenarios and randomized backpressure jobs.
module tb_qconv_loop_sequencer;

  logic       clk, rst, start, abort;
  logic [3:0] oc_high_num, ic_high_num;
  logic [1:0] kh_num, kw_num;
  logic       step_valid, step_ready, acc_clear, acc_last;
  logic       store_valid, store_ready, busy, finish;
  logic [3:0] oc_idx, ic_idx;
  logic [1:0] kh_idx, kw_idx;

  qconv_loop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .oc_high_num(oc_high_num), .ic_high_num(ic_high_num),
    .kh_num(kh_num), .kw_num(kw_num),
    .step_valid(step_valid), .step_ready(step_ready),
    .oc_idx(oc_idx), .ic_idx(ic_idx), .kh_idx(kh_idx), .kw_idx(kw_idx),
    .acc_clear(acc_clear), .acc_last(acc_last),
    .store_valid(store_valid), .store_ready(store_ready),
    .busy(busy), .finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready generation: 0 = always ready, 1 = low on odd cycles after start, 2 = random.
  int   sr_mode = 0;
  int   st_mode = 0;
  logic st_dir = 1'b1;
  logic tog_r = 1'b1, rnd_r = 1'b1, st_rnd = 1'b1;

  always @(posedge clk) begin
    #2;
    tog_r  = (((cyc - t0) % 2) == 0);
    rnd_r  = 1'($urandom_range(0, 1));
    st_rnd = 1'($urandom_range(0, 1));
  end

  assign step_ready  = (sr_mode == 0) ? 1'b1 : (sr_mode == 1) ? tog_r : rnd_r;
  assign store_ready = (st_mode == 0) ? st_dir : st_rnd;

  logic [17:0] outvec;
  assign outvec = {step_valid, oc_idx, ic_idx, kh_idx, kw_idx, acc_clear, acc_last,
                   store_valid, busy, finish};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state and observations.
  logic [31:0] exp_steps[$];
  int          exp_st[$];
  int          clr_q[$], last_q[$], st_q[$];
  int          steps = 0, stores = 0, fins = 0, fin_rel = -1;
  logic        held = 1'b0;
  logic [31:0] prev_step = '0;

  function automatic logic [31:0] pack(input int o, input int i, input int h, input int w,
                                       input bit c, input bit l);
    return 32'((o << 10) | (i << 6) | (h << 4) | (w << 2) | (int'(c) << 1) | int'(l));
  endfunction

  task automatic prep(input int o, input int i, input int h, input int w);
    exp_steps.delete(); exp_st.delete();
    clr_q.delete(); last_q.delete(); st_q.delete();
    steps = 0; stores = 0; fins = 0; fin_rel = -1;
    if (o > 0 && i > 0 && h > 0 && w > 0) begin
      for (int a = 0; a < o; a++) begin
        for (int b = 0; b < i; b++)
          for (int c = 0; c < h; c++)
            for (int d = 0; d < w; d++)
              exp_steps.push_back(pack(a, b, c, d, (b == 0 && c == 0 && d == 0),
                                       (b == i - 1 && c == h - 1 && d == w - 1)));
        exp_st.push_back(a);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] cur;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (step_valid) begin
        cur = {18'd0, oc_idx, ic_idx, kh_idx, kw_idx, acc_clear, acc_last};
        if (held) check("step_hold", cur, prev_step);
        if (step_ready) begin
          steps++;
          check("step_pending", 32'(exp_steps.size() > 0), 1);
          if (exp_steps.size() > 0) check("step_seq", cur, exp_steps.pop_front());
          if (acc_clear) clr_q.push_back(cyc - t0);
          if (acc_last) last_q.push_back(cyc - t0);
          held = 1'b0;
        end else begin
          held = 1'b1;
          prev_step = cur;
        end
      end else begin
        held = 1'b0;
      end
      if (store_valid) begin
        check("store_no_step", 32'(step_valid), 0);
        if (store_ready) begin
          stores++;
          st_q.push_back(cyc - t0);
          check("store_pending", 32'(exp_st.size() > 0), 1);
          if (exp_st.size() > 0) check("store_oc", 32'(oc_idx), 32'(exp_st.pop_front()));
        end
      end
      if (finish) begin
        fins++;
        fin_rel = cyc - t0;
      end
    end
  end

  task automatic start_job(input int o, input int i, input int h, input int w);
    prep(o, i, h, w);
    @(posedge clk); #1;
    oc_high_num = 4'(o); ic_high_num = 4'(i); kh_num = 2'(h); kw_num = 2'(w);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < budget), 1);
    @(negedge clk);
  endtask

  task automatic check_totals(input string tag, input int s, input int st, input int f);
    check({tag, "_steps"}, 32'(steps), 32'(s));
    check({tag, "_stores"}, 32'(stores), 32'(st));
    check({tag, "_finish"}, 32'(fins), 32'(f));
    check({tag, "_model_left"}, 32'(exp_steps.size() + exp_st.size()), 0);
  endtask

  initial begin
    int exp_cl[3], exp_la[3], exp_sq[3];
    int n, o, i, h, w;
    exp_cl = '{1, 23, 45};
    exp_la = '{18, 40, 62};
    exp_sq = '{22, 44, 66};
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    oc_high_num = '0; ic_high_num = '0; kh_num = '0; kw_num = '0;
    #12;
    check("reset_outputs", 32'(outvec), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Baseline job with full readiness and exact cycle positions.
    start_job(3, 2, 3, 3);
    wait_idle("A", 300);
    check_totals("A", 54, 3, 1);
    check("A_finish_cycle", 32'(fin_rel), 67);
    check("A_nclear", 32'(clr_q.size()), 3);
    check("A_nlast", 32'(last_q.size()), 3);
    check("A_nstore", 32'(st_q.size()), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < clr_q.size()) check("A_clear_cycle", 32'(clr_q[k]), 32'(exp_cl[k]));
      if (k < last_q.size()) check("A_last_cycle", 32'(last_q[k]), 32'(exp_la[k]));
      if (k < st_q.size()) check("A_store_cycle", 32'(st_q[k]), 32'(exp_sq[k]));
    end

    // Alternating step_ready: same order, 54 extra cycles.
    sr_mode = 1;
    start_job(3, 2, 3, 3);
    wait_idle("B", 400);
    check_totals("B", 54, 3, 1);
    check("B_finish_cycle", 32'(fin_rel), 67 + 54);
    sr_mode = 0;

    // Store backpressure at the first STORE.
    st_dir = 1'b0;
    start_job(3, 2, 3, 3);
    n = 0;
    while (!store_valid && n < 100) begin @(negedge clk); n++; end
    check("C_store_seen", 32'(store_valid), 1);
    for (int k = 0; k < 5; k++) begin
      check("C_store_hold", {29'd0, store_valid, step_valid, 1'b0}, 32'd4);
      check("C_store_oc", 32'(oc_idx), 0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk); #1 st_dir = 1'b1;
    wait_idle("C", 300);
    check_totals("C", 54, 3, 1);

    // Zero count: straight to DONE.
    start_job(2, 2, 0, 2);
    @(negedge clk);
    check("D_done", {30'd0, busy, finish}, 32'd3);
    @(negedge clk);
    check("D_idle", {30'd0, busy, finish}, 32'd0);
    check_totals("D", 0, 0, 1);

    // Abort in the second block's DRAIN.
    start_job(3, 2, 3, 3);
    n = 0;
    while ((cyc - t0) != 42 && n < 100) begin @(posedge clk); #1; n++; end
    abort = 1'b1;
    @(negedge clk);
    check("E_in_drain", {29'd0, busy, step_valid, store_valid}, 32'd4);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("E_abort_idle", 32'(outvec), 0);
    check("E_stores", 32'(stores), 1);
    repeat (5) @(negedge clk);
    check("E_no_finish", 32'(fins), 0);
    @(posedge clk); #1 abort = 1'b1; start = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("E_idle_abort_blocks_start", 32'(busy), 0);
    start_job(1, 1, 1, 1);
    wait_idle("E2", 50);
    check_totals("E2", 1, 1, 1);

    // Asynchronous reset in the middle of COMPUTE.
    start_job(3, 2, 3, 3);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("F_async_reset", 32'(outvec), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("F_after_reset", 32'(busy), 0);

    // Maximum counts with random backpressure and start noise while busy.
    sr_mode = 2; st_mode = 1;
    start_job(15, 15, 3, 3);
    n = 0;
    while (busy && n < 20000) begin
      @(posedge clk); #1;
      start = (steps < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      n++;
    end
    start = 1'b0;
    check("G_timeout", 32'(n < 20000), 1);
    @(negedge clk);
    check_totals("G", 2025, 15, 1);

    // Random small jobs.
    for (int j = 0; j < 4; j++) begin
      o = $urandom_range(1, 5); i = $urandom_range(1, 4);
      h = $urandom_range(1, 3); w = $urandom_range(1, 3);
      start_job(o, i, h, w);
      wait_idle("R", 4000);
      check_totals("R", o * i * h * w, o, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
